rob_tag_issuer: RTL
===================

Name: rob_tag_issuer

Overview:
- In-order front end that sits directly upstream of the reorder buffer.
- Accepts in-order requests, stamps each with a sequential tag (0..N-1, wrapping) and issues tag plus payload to the execution lanes.
- The lanes may complete out of order; the reorder buffer consumes their results and restores order.
- Tracks outstanding tags with a credit counter and back-pressures when all N tags are in flight, so no tag is ever reused before it retires.

Parameters:
- N, 8, number of tags; power of two, >= 2; must match the reorder buffer depth.
- W, 8, payload width in bits.
- IDW, $clog2(N), tag width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  upstream request valid.
- req_ready  output  1  issuer can accept a request this cycle.
- req_data  input  W  request payload.
- iss_valid  output  1  issued request valid (registered).
- iss_ready  input  1  execution lanes accept the issued request.
- iss_id  output  IDW  tag attached to the issued request (registered).
- iss_data  output  W  issued payload (registered).
- retire  input  1  one-cycle pulse per entry drained by the reorder buffer; connect to its valid_out.
- outstanding  output  IDW+1  tags accepted and not yet retired.
- empty  output  1  outstanding == 0.
- retire_err  output  1  sticky: retire seen while outstanding == 0.

Behaviour:
- Reset, asynchronous, active-high; while rst is high:
  - iss_valid=0, iss_id=0, iss_data=0.
  - tag pointer = 0, outstanding = 0, retire_err = 0.
  - empty = 1, req_ready = 0.
  - Reset mid-operation discards every in-flight tag and the output register contents.
- full = (outstanding == N).
- req_ready = !rst && !full && (!iss_valid || iss_ready).
  - Combinational from registered state and iss_ready only.
  - No combinational path from retire to req_ready.
- Accept = req_valid && req_ready. On accept, at the next edge:
  - iss_valid <= 1, iss_id <= tag pointer, iss_data <= req_data.
  - Tag pointer <= (pointer + 1) mod N; wraps from N-1 to 0.
  - Latency: request to iss_valid is 1 cycle.
- Output handshake:
  - iss_valid && !iss_ready: iss_valid, iss_id and iss_data hold stable, and no accept occurs.
  - iss_valid && iss_ready && !accept: iss_valid <= 0; iss_id and iss_data hold their last values.
  - Back-to-back issue with iss_ready held high gives 1 request per cycle.
- Outstanding counter update, evaluated each cycle:
  - Accept only: +1.
  - Retire only, outstanding > 0: -1.
  - Accept and retire together: unchanged.
  - Retire with outstanding == 0: counter stays 0; retire_err <= 1 and stays set until reset.
- At full, a retire frees a credit at the next edge; req_ready rises in the following cycle. A retire and an accept never coincide at full.
- outstanding never exceeds N. The counter width IDW+1 holds N exactly.
- Tag sequence is strictly 0,1,...,N-1,0,... regardless of stalls; stalls do not advance the pointer.
- empty is combinational from outstanding.

Optional Feature:
- Macro ISSUER_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 16 bits, reset to 0.
  - Increments on every cycle with req_valid && !req_ready && !rst.
  - Saturates at 16'hFFFF.
  - Has no effect on any other behaviour.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, iss_ready=1, 3 back-to-back requests with data 0xA1,0xA2,0xA3:
  - iss_id 0,1,2 with matching data on consecutive cycles, each 1 cycle after acceptance.
  - outstanding ends at 3.
- Fill: 8 accepts with no retire:
  - outstanding=8, req_ready=0.
  - A 9th request is held; it issues with iss_id=0 exactly 1 cycle after the first retire pulse takes effect.
- Stall: iss_ready=0 after the first issue of data 0x55, id 0:
  - iss_valid, iss_id and iss_data stay 1/0/0x55; req_ready=0.
  - On iss_ready=1 the next request issues with id 1.
- Simultaneous events: with outstanding=4, accept plus retire in the same cycle:
  - outstanding stays 4.
  - The tag pointer still advances by 1.
- Spurious retire at outstanding=0:
  - retire_err=1 and stays 1; outstanding stays 0.
  - Reset clears retire_err.
- Mid-stream reset with outstanding=5 and iss_valid=1:
  - All outputs go to reset values immediately (asynchronous).
  - After release, the first issue uses iss_id=0.
  - With ISSUER_STALL_CNT_EN defined, stall_cnt reads 0.

Source files
------------

// File: rtl/rob_tag_issuer.sv
// rob_tag_issuer: stamps in-order requests with wrapping tags and issues them, gated by a tag credit count
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   req_valid/ready/data upstream request handshake and payload
//   iss_valid/ready      registered issue handshake toward the execution lanes
//   iss_id, iss_data     registered tag and payload of the issued request
//   retire               one-cycle pulse per entry drained by the reorder buffer
//   outstanding          tags accepted and not yet retired (0..N)
//   empty                outstanding == 0
//   retire_err           sticky flag: retire seen while nothing was outstanding
//   stall_cnt            saturating count of cycles with req_valid && !req_ready
//                        (present only when ISSUER_STALL_CNT_EN is defined)
module rob_tag_issuer #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [W-1:0]         req_data,
   output logic                 iss_valid,
   input  logic                 iss_ready,
   output logic [$clog2(N)-1:0] iss_id,
   output logic [W-1:0]         iss_data,
   input  logic                 retire,
   output logic [$clog2(N):0]   outstanding,
   output logic                 empty,
   output logic                 retire_err
`ifdef ISSUER_STALL_CNT_EN
   ,
   output logic [15:0]          stall_cnt
`endif
);
   localparam int IDW = $clog2(N);
   localparam logic [IDW:0] FULL_CNT = (IDW + 1)'(N);

   logic           vld_q, vld_d;
   logic [IDW-1:0] id_q, id_d;
   logic [W-1:0]   data_q, data_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW:0]   out_q, out_d;
   logic           err_q, err_d;
   logic           full, acc, ret_ok;

   assign full      = out_q == FULL_CNT;
   assign req_ready = !rst && !full && (!vld_q || iss_ready);
   assign acc       = req_valid && req_ready;
   // a retire with nothing outstanding is spurious and never touches the count
   assign ret_ok    = retire && out_q != '0;

   always_comb begin
      vld_d  = acc ? 1'b1 : (iss_ready ? 1'b0 : vld_q);
      id_d   = acc ? ptr_q : id_q;
      data_d = acc ? req_data : data_q;
      // N is a power of two, so natural overflow of the IDW-bit pointer is the wrap
      ptr_d  = acc ? ptr_q + 1'b1 : ptr_q;
      out_d  = (acc && !ret_ok) ? out_q + 1'b1 : ((!acc && ret_ok) ? out_q - 1'b1 : out_q);
      err_d  = err_q || (retire && out_q == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= 1'b0;
         id_q   <= '0;
         data_q <= '0;
         ptr_q  <= '0;
         out_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         id_q   <= id_d;
         data_q <= data_d;
         ptr_q  <= ptr_d;
         out_q  <= out_d;
         err_q  <= err_d;
      end
   end

   assign iss_valid   = vld_q;
   assign iss_id      = id_q;
   assign iss_data    = data_q;
   assign outstanding = out_q;
   assign empty       = out_q == '0;
   assign retire_err  = err_q;

`ifdef ISSUER_STALL_CNT_EN
   logic [15:0] sc_q, sc_d;

   assign sc_d = (req_valid && !req_ready && !rst && sc_q != 16'hFFFF) ? sc_q + 16'd1 : sc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sc_q <= '0;
      else     sc_q <= sc_d;
   end

   assign stall_cnt = sc_q;
`endif
endmodule
